rep_code_serial_tx: RTL and testbench

Repetition-code serial transmitter. It accepts a parallel data word through a valid/ready handshake and sends it LSB first on a single-bit line. Each bit is held for REP consecutive slots, and slots advance on an external `bit_tick` strobe. It is the transmit end of the team's redundant serial link, and its output feeds the existing REP-input majority voter on the receive side.

---
 rtl/rep_code_serial_tx.sv | 120 ++++++++++++
 tb/tb_rep_code_serial_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rep_code_serial_tx.sv
// Repetition-code serial transmitter: sends a parallel word LSB first, each bit
// held for REP bit_tick slots, followed by one idle GAP slot.
module rep_code_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              frame_done
);

  localparam int REP_W = $clog2(REP);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [REP_W-1:0]   rep_cnt_reg, rep_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [BIT_W-1:0]   bit_inc;
  logic               tx_bit_reg, tx_bit_next;
  logic               tx_valid_reg, tx_valid_next;
  logic               tx_sof_reg, tx_sof_next;
  logic               frame_done_reg, frame_done_next;

  assign bit_inc = bit_cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      rep_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      tx_bit_reg     <= 1'b0;
      tx_valid_reg   <= 1'b0;
      tx_sof_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      rep_cnt_reg    <= rep_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      tx_bit_reg     <= tx_bit_next;
      tx_valid_reg   <= tx_valid_next;
      tx_sof_reg     <= tx_sof_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Line outputs are computed one edge ahead so they stay glitch-free registers.
  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    rep_cnt_next    = rep_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    tx_bit_next     = tx_bit_reg;
    tx_valid_next   = tx_valid_reg;
    tx_sof_next     = tx_sof_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next    = SEND;
          data_next     = in_data;
          rep_cnt_next  = '0;
          bit_cnt_next  = '0;
          tx_bit_next   = in_data[0];
          tx_valid_next = 1'b1;
          tx_sof_next   = 1'b1;
        end
      end
      SEND: begin
        if (bit_tick) begin
          tx_sof_next = 1'b0;
          if (rep_cnt_reg != REP_LAST) begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end else if (bit_cnt_reg != BIT_LAST) begin
            rep_cnt_next = '0;
            bit_cnt_next = bit_inc;
            tx_bit_next  = data_reg[bit_inc];
          end else begin
            // Counters stay at their terminal values until the next acceptance.
            state_next      = GAP;
            tx_valid_next   = 1'b0;
            tx_bit_next     = 1'b0;
            frame_done_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        tx_valid_next = 1'b0;
        tx_bit_next   = 1'b0;
        tx_sof_next   = 1'b0;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign tx_bit     = tx_bit_reg;
  assign tx_valid   = tx_valid_reg;
  assign tx_sof     = tx_sof_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_rep_code_serial_tx.sv
// Bench for rep_code_serial_tx: models each frame as a list of tick-indexed slots
// and checks the line outputs every cycle for 8x5 and 4x3 instances.
module tb_rep_code_serial_tx;

  localparam int DW = 8;
  localparam int RP = 5;
  localparam int N  = DW * RP;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_tick, in_valid;
  logic [7:0] in_data;
  logic       in_ready, tx_bit, tx_valid, tx_sof, frame_done;

  logic       bit_tick2, in_valid2;
  logic [3:0] in_data2;
  logic       in_ready2, tx_bit2, tx_valid2, tx_sof2, frame_done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rep_code_serial_tx #(.DATA_W(DW), .REP(RP)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx_bit(tx_bit),
    .tx_valid(tx_valid), .tx_sof(tx_sof), .frame_done(frame_done)
  );

  rep_code_serial_tx #(.DATA_W(4), .REP(3)) dut2 (
    .clk(clk), .rst(rst), .bit_tick(bit_tick2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .tx_bit(tx_bit2),
    .tx_valid(tx_valid2), .tx_sof(tx_sof2), .frame_done(frame_done2)
  );

  // One frame on the 8x5 instance. k counts ticks consumed since SEND entry;
  // the expected line for each cycle follows directly from k.
  task automatic run_frame(input logic [7:0] word, input int period, input bit tick_accept,
                           input bit hold, input logic [7:0] next_word, input bit rnd);
    int k = 0;
    int cyc = 0;
    int gap_cyc = 0;
    int vcnt = 0;
    int dcnt = 0;
    bit tick;
    logic [4:0] exp_v, act_v;
    @(negedge clk);
    act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
    total++;
    if (act_v !== 5'b10000) begin
      bad++;
      $display("FAIL idle_before word=%h got=%b want=10000", word, act_v);
    end
    in_valid = 1'b1;
    in_data  = word;
    bit_tick = tick_accept;
    while (k <= N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) in_valid = 1'b0;
      if (hold && k == N / 2) in_data = next_word;
      if (k < N) begin
        exp_v = {1'b0, 1'b1, word[k / RP], (k == 0), 1'b0};
      end else begin
        exp_v = {4'b0000, (gap_cyc == 0)};
        gap_cyc++;
      end
      act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL slot word=%h k=%0d cyc=%0d got=%b want=%b (rdy,vld,bit,sof,done)",
                 word, k, cyc, act_v, exp_v);
      end
      vcnt += int'(tx_valid);
      dcnt += int'(frame_done);
      tick = rnd ? ($urandom_range(0, 2) == 0) : ((cyc % period) == 0);
      bit_tick = tick;
      if (tick) k++;
    end
    total++;
    if (k <= N) begin
      bad++;
      $display("FAIL timeout word=%h got k=%0d want k=%0d", word, k, N + 1);
    end
    total++;
    if (dcnt != 1) begin
      bad++;
      $display("FAIL done_count word=%h got=%0d want=1", word, dcnt);
    end
    if (period == 1 && !rnd) begin
      total++;
      if (vcnt != N) begin
        bad++;
        $display("FAIL valid_cycles word=%h got=%0d want=%0d", word, vcnt, N);
      end
    end
    $display("frame word=%h period=%0d tick_accept=%0d hold=%0d rnd=%0d cycles=%0d", word, period,
             tick_accept, hold, rnd, cyc);
  endtask

  task automatic test_reset;
    logic [4:0] act_v;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; bit_tick = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; bit_tick2 = 1'b0;
    @(negedge clk);
    act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
    total++;
    if (act_v !== 5'b10000) begin
      bad++;
      $display("FAIL reset_state got=%b want=10000", act_v);
    end
    act_v = {in_ready2, tx_valid2, tx_bit2, tx_sof2, frame_done2};
    total++;
    if (act_v !== 5'b10000) begin
      bad++;
      $display("FAIL reset_state2 got=%b want=10000", act_v);
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic;
    run_frame(8'hA5, 1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_sparse;
    run_frame(8'h01, 3, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_frame(8'h3C, 1, 1'b0, 1'b1, 8'hC3, 1'b0);
    run_frame(8'hC3, 1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_tick_collision;
    run_frame(8'h5A, 1, 1'b1, 1'b0, 8'h00, 1'b0);
    run_frame(8'h96, 2, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom), 1, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_mid_reset;
    logic [4:0] act_v;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; bit_tick = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; bit_tick = 1'b1;
    repeat (17) @(negedge clk);
    act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
    total++;
    if (act_v !== 5'b01100) begin
      bad++;
      $display("FAIL pre_abort got=%b want=01100", act_v);
    end
    #2 rst = 1'b1;
    #1;
    act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
    total++;
    if (act_v !== 5'b10000) begin
      bad++;
      $display("FAIL async_abort got=%b want=10000", act_v);
    end
    bit_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      act_v = {in_ready, tx_valid, tx_bit, tx_sof, frame_done};
      total++;
      if (act_v !== 5'b10000) begin
        bad++;
        $display("FAIL held_reset cyc=%0d got=%b want=10000", i, act_v);
      end
    end
    rst = 1'b0;
    $display("mid-frame reset at slot 17 checked");
    run_frame(8'h0F, 1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // 4x3 instance: sequence for 4'b1010 is 0,0,0,1,1,1,0,0,0,1,1,1 (index 0 first).
  task automatic test_param_sweep;
    logic [3:0]  word = 4'b1010;
    logic [11:0] seq = '0;
    logic [11:0] want_seq = 12'b111000111000;
    logic [4:0]  exp_v, act_v;
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = word; bit_tick2 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      if (c <= 12) begin
        exp_v = {1'b0, 1'b1, word[(c - 1) / 3], (c == 1), 1'b0};
        seq[c - 1] = tx_bit2;
      end else if (c == 13) begin
        exp_v = 5'b00001;
      end else begin
        exp_v = 5'b10000;
      end
      act_v = {in_ready2, tx_valid2, tx_bit2, tx_sof2, frame_done2};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL sweep_slot cyc=%0d got=%b want=%b", c, act_v, exp_v);
      end
    end
    bit_tick2 = 1'b0;
    total++;
    if (seq !== want_seq) begin
      bad++;
      $display("FAIL sweep_seq got=%b want=%b", seq, want_seq);
    end
    $display("sweep DATA_W=4 REP=3 word=%b seq=%b", word, seq);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sparse;
    test_back_to_back;
    test_tick_collision;
    test_random;
    test_mid_reset;
    test_param_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
